apb_register_completer: RTL and testbench

- APB4 completer (slave end) that terminates an APB requester port, such as the m00 port of an APB NIC, into a bank of NUM_REGS software-visible registers.
- Adds programmable wait states, byte-strobed writes and error responses.
- Register contents and per-register write pulses are exported to hardware.
- Used as the leaf peripheral behind the NIC in tests and as the CSR block for accelerator subsystems.

---
 rtl/apb_completer_pkg.sv | 27 ++
 rtl/apb_reg_bank.sv | 68 ++++++
 rtl/apb_register_completer.sv | 145 ++++++++++++++
 tb/tb_apb_register_completer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_completer_pkg.sv
// Shared types and default geometry for the APB register completer.
//   state_e  : completer FSM states (IDLE, ACCESS).
//   STRB_W / IDX_W / OFS_W : byte-lane, register-index and byte-offset widths
//                            for the default 32-bit, 16-register build.
//   decode_t : result of address decode (register index plus error flag).
//              idx is sized for the largest supported bank; the top module
//              uses only its low IDX bits.
package apb_completer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int DEF_DW       = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int STRB_W       = DEF_DW / 8;
  localparam int IDX_W        = $clog2(DEF_NUM_REGS);
  localparam int OFS_W        = $clog2(DEF_DW / 8);
  localparam int MAX_IDX_W    = 16;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 err;
  } decode_t;

endpackage

// File: rtl/apb_reg_bank.sv
// Byte-strobed register bank behind the APB completer.
//   clock, resetn : clock and asynchronous active-low reset.
//   we            : commit a write this cycle.
//   idx           : register written when we=1.
//   wdata, strb   : write data and per-byte enables.
//   rd_idx        : register presented on rd_data (combinational).
//   reg_q         : all registers, flattened; register i at [i*DW +: DW].
//   reg_wr_pulse  : one-cycle registered pulse after each committed write,
//                   including writes whose strobes are all zero.
module apb_reg_bank #(
  parameter int DW       = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [DW-1:0]            wdata,
  input  logic [DW/8-1:0]          strb,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DW-1:0]            rd_data,
  output logic [NUM_REGS*DW-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int NBYTES = DW / 8;

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q, pulse_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    regs_d  = regs_q;
    pulse_d = '0;
    if (we) begin
      pulse_d = NUM_REGS'(1) << idx;
      for (int b = 0; b < NBYTES; b++) begin
        if (strb[b]) regs_d[idx][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  // NOTE: these are individual flops, not a RAM macro, so clearing the whole
  // array on reset is cheap and gives software a known power-on value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DW +: DW] = regs_q[i];
  end

  assign rd_data      = regs_q[rd_idx];
  assign reg_wr_pulse = pulse_q;

endmodule

// File: rtl/apb_register_completer.sv
// APB4 completer terminating a requester port into NUM_REGS registers.
//   clock, resetn      : clock and asynchronous active-low reset.
//   s00_paddr..pstrb   : APB request; sampled and held at the setup edge.
//   s00_pready         : transfer complete (combinational from FSM + counter).
//   s00_pslverr        : error response, only with pready.
//   s00_prdata         : read data, only with pready on a successful read.
//   reg_q              : flattened register contents.
//   reg_wr_pulse       : one-cycle pulse after each committed write.
// Every access phase holds pready low for WAIT_CYCLES cycles. Out-of-range,
// misaligned and (when PRIV_WRITE=1) unprivileged writes complete with
// pslverr and no side effects.
module apb_register_completer
  import apb_completer_pkg::*;
#(
  parameter int S00_AW      = 32,
  parameter int S00_DW      = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int PRIV_WRITE  = 0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [S00_AW-1:0]          s00_paddr,
  input  logic [2:0]                 s00_pprot,
  input  logic                       s00_psel,
  input  logic                       s00_penable,
  input  logic                       s00_pwrite,
  input  logic [S00_DW-1:0]          s00_pwdata,
  input  logic [S00_DW/8-1:0]        s00_pstrb,
  output logic                       s00_pready,
  output logic                       s00_pslverr,
  output logic [S00_DW-1:0]          s00_prdata,
  output logic [NUM_REGS*S00_DW-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  localparam int NBYTES   = S00_DW / 8;
  localparam int IDX_BITS = $clog2(NUM_REGS);
  localparam int OFS_BITS = $clog2(NBYTES);
  localparam logic [S00_AW-1:0] SPAN     = S00_AW'(NUM_REGS * NBYTES);
  localparam logic [S00_AW-1:0] OFS_MASK = S00_AW'(NBYTES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [S00_AW-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                priv_q, priv_d;
  logic [S00_DW-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]   strb_q, strb_d;

  logic [S00_AW-1:0]   word_addr;
  decode_t             dec;
  logic [S00_DW-1:0]   rd_data;
  logic                commit;

  // Decode works on the values held at setup, so bus changes during the
  // access phase cannot alter the target or the error outcome.
  assign word_addr = addr_q >> OFS_BITS;

  always_comb begin
    dec.idx = MAX_IDX_W'(word_addr[IDX_BITS-1:0]);
    dec.err = (addr_q >= SPAN)
            || ((addr_q & OFS_MASK) != '0)
            || ((PRIV_WRITE != 0) && wr_q && !priv_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    priv_d  = priv_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    unique case (state_q)
      IDLE: begin
        if (s00_psel && !s00_penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = s00_paddr;
          wr_d    = s00_pwrite;
          priv_d  = s00_pprot[0];
          wdata_d = s00_pwdata;
          strb_d  = s00_pstrb;
        end
      end
      ACCESS: begin
        if (!s00_psel) begin
          state_d = IDLE;
        end else if (s00_penable) begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      priv_q  <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      priv_q  <= priv_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  assign s00_pready  = (state_q == ACCESS) && (cnt_q == 4'd0) && s00_psel && s00_penable;
  assign s00_pslverr = s00_pready && dec.err;
  assign s00_prdata  = (s00_pready && !wr_q && !dec.err) ? rd_data : '0;
  assign commit      = s00_pready && wr_q && !dec.err;

  apb_reg_bank #(
    .DW       (S00_DW),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_BITS)
  ) u_bank (
    .clock        (clock),
    .resetn       (resetn),
    .we           (commit),
    .idx          (dec.idx[IDX_BITS-1:0]),
    .wdata        (wdata_q),
    .strb         (strb_q),
    .rd_idx       (dec.idx[IDX_BITS-1:0]),
    .rd_data      (rd_data),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  // Bits that are deliberately not consumed by the logic above.
  logic unused_bits;
  assign unused_bits = ^{s00_pprot[2:1], word_addr, dec.idx};

endmodule

// File: tb/tb_apb_register_completer.sv
// Self-checking bench: three completer instances with different wait-state
// and privilege settings, each checked against a register-array model.
module tb_apb_register_completer;

  localparam int ND = 3;
  localparam int WAIT_C [ND] = '{0, 2, 3};
  localparam int PRIV_C [ND] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n;

  logic [31:0]  paddr   [ND];
  logic [2:0]   pprot   [ND];
  logic         psel    [ND];
  logic         penable [ND];
  logic         pwrite  [ND];
  logic [31:0]  pwdata  [ND];
  logic [3:0]   pstrb   [ND];
  logic         pready  [ND];
  logic         pslverr [ND];
  logic [31:0]  prdata  [ND];
  logic [511:0] regs    [ND];
  logic [15:0]  pulse   [ND];

  logic [31:0] model     [ND][16];
  int          exp_pulse [ND][16];
  int          got_pulse [ND][16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_register_completer #(
      .S00_AW(32), .S00_DW(32), .NUM_REGS(16),
      .WAIT_CYCLES(WAIT_C[g]), .PRIV_WRITE(PRIV_C[g])
    ) u_dut (
      .clock        (clk),
      .resetn       (rst_n),
      .s00_paddr    (paddr[g]),
      .s00_pprot    (pprot[g]),
      .s00_psel     (psel[g]),
      .s00_penable  (penable[g]),
      .s00_pwrite   (pwrite[g]),
      .s00_pwdata   (pwdata[g]),
      .s00_pstrb    (pstrb[g]),
      .s00_pready   (pready[g]),
      .s00_pslverr  (pslverr[g]),
      .s00_prdata   (prdata[g]),
      .reg_q        (regs[g]),
      .reg_wr_pulse (pulse[g])
    );
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 16; i++)
        if (pulse[d][i] === 1'b1) got_pulse[d][i]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_model();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // One complete APB transfer; expectations come from the model's view of
  // the address map, wait-state count and error rules.
  task automatic xfer(input int d, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot);
    bit          err;
    bit          done;
    int          idx;
    int          n;
    logic [31:0] exp_rd;
    err    = (addr >= 32'h40) || (addr[1:0] != 2'b00) ||
             (PRIV_C[d] != 0 && wr && !prot[0]);
    idx    = int'(addr[5:2]);
    exp_rd = err ? 32'h0 : model[d][idx];
    @(negedge clk);
    paddr[d] = addr; pwrite[d] = wr; pwdata[d] = wdata;
    pstrb[d] = strb; pprot[d] = prot;
    psel[d]  = 1'b1; penable[d] = 1'b0;
    @(posedge clk);
    n = 0; done = 0;
    while (!done && n <= WAIT_C[d] + 3) begin
      @(negedge clk);
      penable[d] = 1'b1;
      paddr[d]  = $urandom; pwdata[d] = $urandom;
      pstrb[d]  = 4'($urandom); pwrite[d] = 1'($urandom);
      pprot[d]  = 3'($urandom);
      #1;
      if (pready[d] === 1'b1) begin
        done = 1;
        total++;
        if (n != WAIT_C[d]) begin
          bad++;
          $display("FAIL wait_states dut%0d addr=%0h: got %0d want %0d", d, addr, n, WAIT_C[d]);
        end
        total++;
        if (pslverr[d] !== err) begin
          bad++;
          $display("FAIL pslverr dut%0d addr=%0h wr=%0d: got %b want %b", d, addr, wr, pslverr[d], err);
        end
        if (!wr) begin
          total++;
          if (prdata[d] !== exp_rd) begin
            bad++;
            $display("FAIL prdata dut%0d addr=%0h: got %h want %h", d, addr, prdata[d], exp_rd);
          end
        end
      end else begin
        total++;
        if (pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
          bad++;
          $display("FAIL quiet_outputs dut%0d: got pslverr=%b prdata=%h want 0/0", d, pslverr[d], prdata[d]);
        end
      end
      @(posedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout dut%0d addr=%0h: got no pready want pready after %0d waits", d, addr, WAIT_C[d]);
    end
    if (done && wr && !err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
      exp_pulse[d][idx]++;
    end
  endtask

  task automatic check_regs(input int d);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (regs[d][i*32 +: 32] !== model[d][i]) begin
        bad++;
        $display("FAIL reg_q dut%0d reg%0d: got %h want %h", d, i, regs[d][i*32 +: 32], model[d][i]);
      end
    end
  endtask

  task automatic check_pulses(input int d);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got_pulse[d][i] != exp_pulse[d][i]) begin
        bad++;
        $display("FAIL pulse_count dut%0d reg%0d: got %0d want %0d", d, i, got_pulse[d][i], exp_pulse[d][i]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < ND; d++) begin
      total++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0 ||
          regs[d] !== 512'h0 || pulse[d] !== 16'h0) begin
        bad++;
        $display("FAIL %s dut%0d: got pready=%b pslverr=%b prdata=%h pulse=%h regs_nonzero=%b want all 0",
                 tag, d, pready[d], pslverr[d], prdata[d], pulse[d], regs[d] != 512'h0);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
      for (int i = 0; i < 16; i++) begin
        exp_pulse[d][i] = 0; got_pulse[d][i] = 0;
      end
    end
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    xfer(0, 32'h08, 1, 32'hDEADBEEF, 4'hF, 3'b000);
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    total++;
    if (pulse[0] !== 16'h0004) begin
      bad++;
      $display("FAIL write_pulse dut0: got %h want %h", pulse[0], 16'h0004);
    end
    xfer(0, 32'h08, 0, 32'h0, 4'h0, 3'b000);
    idle(0);
    check_regs(0);
  endtask

  task automatic test_wait_strobe();
    xfer(1, 32'h04, 1, 32'h11223344, 4'hF, 3'b001);
    xfer(1, 32'h04, 1, 32'hAABBCCDD, 4'h5, 3'b001);
    idle(1);
    total++;
    if (regs[1][63:32] !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL strobe_merge dut1: got %h want %h", regs[1][63:32], 32'h11BB33DD);
    end
    xfer(1, 32'h04, 0, 32'h0, 4'h0, 3'b001);
    idle(1);
  endtask

  task automatic test_errors();
    xfer(0, 32'h40, 0, 32'h0, 4'h0, 3'b000);
    xfer(0, 32'h06, 0, 32'h0, 4'h0, 3'b000);
    xfer(0, 32'h40, 1, 32'h12345678, 4'hF, 3'b000);
    xfer(0, 32'h0A, 1, 32'h12345678, 4'hF, 3'b000);
    idle(0);
    check_regs(0);
    check_pulses(0);
  endtask

  task automatic test_priv();
    xfer(1, 32'h00, 1, 32'h1, 4'hF, 3'b000);
    idle(1);
    check_regs(1);
    xfer(1, 32'h00, 1, 32'h1, 4'hF, 3'b001);
    xfer(1, 32'h00, 0, 32'h0, 4'h0, 3'b000);
    idle(1);
    check_regs(1);
    check_pulses(1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      xfer(0, 32'(k * 4), 1, $urandom, 4'hF, 3'b000);
    for (int k = 0; k < 4; k++)
      xfer(0, 32'(k * 4), 0, 32'h0, 4'h0, 3'b000);
    idle(0);
    idle(0);
    check_regs(0);
    check_pulses(0);
  endtask

  task automatic test_abort();
    xfer(2, 32'h14, 1, 32'h0BADF00D, 4'hF, 3'b000);
    @(negedge clk);
    paddr[2] = 32'h14; pwrite[2] = 1'b1; pwdata[2] = 32'hCAFEBABE;
    pstrb[2] = 4'hF; psel[2] = 1'b1; penable[2] = 1'b0;
    @(negedge clk);
    penable[2] = 1'b1;
    #1;
    total++;
    if (pready[2] !== 1'b0) begin
      bad++;
      $display("FAIL abort_early_pready dut2: got %b want 0", pready[2]);
    end
    @(negedge clk);
    psel[2] = 1'b0; penable[2] = 1'b0;
    idle(2);
    idle(2);
    check_regs(2);
    xfer(2, 32'h18, 1, 32'h5A5A5A5A, 4'hF, 3'b000);
    xfer(2, 32'h14, 0, 32'h0, 4'h0, 3'b000);
    idle(2);
    idle(2);
    check_regs(2);
    check_pulses(2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    paddr[1] = 32'h0C; pwrite[1] = 1'b1; pwdata[1] = 32'h76543210;
    pstrb[1] = 4'hF; pprot[1] = 3'b001; psel[1] = 1'b1; penable[1] = 1'b0;
    @(negedge clk);
    penable[1] = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_access");
    clear_model();
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 32'h0C, 1, 32'h00C0FFEE, 4'hF, 3'b001);
    xfer(1, 32'h0C, 0, 32'h0, 4'h0, 3'b001);
    idle(1);
    check_regs(1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 60; k++) begin
        case ($urandom_range(0, 9))
          0:       addr = 32'h40 + 32'($urandom_range(0, 63));
          1:       addr = 32'($urandom_range(0, 63));
          default: addr = 32'($urandom_range(0, 15) * 4);
        endcase
        xfer(d, addr, 1'($urandom), $urandom, 4'($urandom), 3'($urandom));
        if ($urandom_range(0, 3) == 0) idle(d);
      end
      idle(d);
      idle(d);
      check_regs(d);
      check_pulses(d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_strobe();
    test_errors();
    test_priv();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
